// File: rtl/exec_wb_stage.sv
// Execute/writeback stage behind the 8-bit ALU: status registers, LW/SW memory handshake, register-file writeback.
// Optional memory-ack timeout with sticky ERR is enabled by defining EXEC_WB_TIMEOUT_EN.
module exec_wb_stage #(
  parameter int DATA_W         = 8,
  parameter int REG_AW         = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        OP,
  input  logic [2:0]        FUNC,
  input  logic [REG_AW-1:0] DST,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              ALU_FLAG,
  input  logic              ALU_OVF,
  input  logic [DATA_W-1:0] STORE_DATA,
  output logic              FLAG,
  output logic              OVERFLOW,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              RF_WE,
  output logic [REG_AW-1:0] RF_WADDR,
  output logic [DATA_W-1:0] RF_WDATA,
  output logic              BUSY,
  output logic              ERR
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CEQ = 3'd2;
  localparam logic [2:0] OP_CLT = 3'd3;
  localparam logic [2:0] OP_SEI = 3'd4;
  localparam logic [2:0] OP_LW  = 3'd5;
  localparam logic [2:0] OP_SW  = 3'd6;
  localparam logic [2:0] OP_O   = 3'd7;

  // fnSHIFTL_X/F/O = 0..2, fnSHIFTR_X/F/O = 3..5; 6 and 7 are not shifts
  localparam logic [2:0] FN_SHIFT_LAST = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_WB       = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_flag;
  logic                r_ovf;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_rf_we;
  logic [REG_AW-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic                r_busy;
  logic                w_accept;
  logic                w_is_shift;
  logic                w_is_mem;
  logic                w_writes;
  logic                w_sets_ovf;
  logic                w_sets_flag;
  logic                w_timeout;

  assign IN_READY    = (r_state == S_IDLE) || (r_state == S_WB);
  assign w_accept    = IN_VALID && IN_READY;
  assign w_is_shift  = (OP == OP_O) && (FUNC <= FN_SHIFT_LAST);
  assign w_is_mem    = (OP == OP_LW) || (OP == OP_SW);
  assign w_writes    = (OP == OP_ADD) || (OP == OP_SUB) || (OP == OP_SEI) ||
                       (OP == OP_LW) || w_is_shift;
  assign w_sets_ovf  = (OP == OP_ADD) || (OP == OP_SUB) || w_is_shift;
  assign w_sets_flag = (OP == OP_CEQ) || (OP == OP_CLT);

`ifdef EXEC_WB_TIMEOUT_EN
  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   W_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Wait-cycle counter: cleared outside MEM_WAIT, counts cycles without ack inside it
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_state != S_MEM_WAIT) begin
      r_cnt <= {CW{1'b0}};
    end else if (!MEM_ACK) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The count reaches the limit on this edge; an ack in the same cycle takes priority
  assign w_timeout = (r_state == S_MEM_WAIT) && !MEM_ACK && (r_cnt == W_LIMIT);

  // Sticky timeout error, cleared only by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign ERR = r_err;
`else
  // Never true; without the timeout MEM_WAIT waits for the ack indefinitely
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign ERR       = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_WB: begin
        if (w_accept) begin
          if (w_is_mem) begin
            w_state_next = S_MEM_WAIT;
          end else if (w_writes) begin
            w_state_next = S_WB;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (MEM_ACK) begin
          w_state_next = r_mem_we ? S_IDLE : S_WB;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_MEM_WAIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status, memory-port and writeback registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_flag      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {DATA_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= {REG_AW{1'b0}};
      r_rf_wdata  <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      r_rf_we <= (w_state_next == S_WB);
      case (r_state)
        S_IDLE, S_WB: begin
          if (w_accept) begin
            r_rf_waddr <= DST;
            if (w_sets_ovf) begin
              r_ovf <= ALU_OVF;
            end
            if (w_sets_flag) begin
              r_flag <= ALU_FLAG;
            end
            if (w_is_mem) begin
              r_mem_req   <= 1'b1;
              r_busy      <= 1'b1;
              r_mem_addr  <= ALU_OUT;
              r_mem_we    <= (OP == OP_SW);
              r_mem_wdata <= STORE_DATA;
            end else begin
              r_rf_wdata <= ALU_OUT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (MEM_ACK) begin
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            if (!r_mem_we) begin
              r_rf_wdata <= MEM_RDATA;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign FLAG      = r_flag;
  assign OVERFLOW  = r_ovf;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign RF_WE     = r_rf_we;
  assign RF_WADDR  = r_rf_waddr;
  assign RF_WDATA  = r_rf_wdata;
  assign BUSY      = r_busy;

endmodule
